// File: rtl/scramb_pkg.sv
// -----------------------------------------------------------------------------
// scramb_pkg
// Shared constants, FSM state type and seed helper for the scrambling-code
// controller slice (scramb_code_ctrl, scramb_chip_slot_cnt).
// -----------------------------------------------------------------------------
package scramb_pkg;

    localparam int SEED_W          = 18;
    localparam int CHIPS_PER_SLOT  = 2560;
    localparam int SLOTS_PER_FRAME = 15;
    localparam int CHIP_W          = 12;
    localparam int SLOT_W          = 4;
    localparam int FRAME_W         = 12;

    localparam logic [SEED_W-1:0] Q_SEED    = 18'h3FFFF;
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CHIPS_PER_SLOT - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // An all-zero seed would lock the LFSR; substitute the smallest legal seed.
    function automatic logic [SEED_W-1:0] safe_seed(input logic [SEED_W-1:0] seed);
        return (seed == '0) ? {{(SEED_W-1){1'b0}}, 1'b1} : seed;
    endfunction

endpackage

// File: rtl/scramb_chip_slot_cnt.sv
// -----------------------------------------------------------------------------
// scramb_chip_slot_cnt
// Chip/slot position counter. Holds the index of the next chip to be issued.
//   clk, reset : clock, synchronous active-low reset
//   inc        : advance by one chip
//   clr        : return to chip 0 / slot 0 (priority over inc)
//   chip_cnt   : chip index within slot, 0..2559
//   slot_cnt   : slot index within frame, 0..14
//   last_chip  : current index is the final chip of the frame (38399)
// -----------------------------------------------------------------------------
module scramb_chip_slot_cnt
    import scramb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [CHIP_W-1:0] chip_cnt,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic              last_chip
);

    logic [CHIP_W-1:0] chip_q;
    logic [SLOT_W-1:0] slot_q;

    // NOTE: reset is sampled only on the clock edge, so it sits inside the
    // edge-triggered block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chip_q <= '0;
            slot_q <= '0;
        end else if (clr) begin
            chip_q <= '0;
            slot_q <= '0;
        end else if (inc) begin
            if (chip_q == CHIP_LAST) begin
                chip_q <= '0;
                slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end else begin
                chip_q <= chip_q + 1'b1;
            end
        end
    end

    assign chip_cnt  = chip_q;
    assign slot_cnt  = slot_q;
    assign last_chip = (chip_q == CHIP_LAST) && (slot_q == SLOT_LAST);

endmodule

// File: rtl/scramb_code_ctrl.sv
// -----------------------------------------------------------------------------
// scramb_code_ctrl
// Controls a scrambling-code generator: loads the I/Q seeds, gates the chip
// strobe into generator advance pulses, tracks chip/slot/frame position and
// reloads the seed at every frame boundary.
//   clk, reset        : clock, synchronous active-low reset
//   start / stop      : begin / halt generation (stop wins)
//   code_num          : I-branch seed, taken on accepted start or cfg_wr
//   cfg_wr            : stage code_num for the next frame boundary (busy only)
//   chip_en           : chip-rate strobe
//   gen_load          : one-cycle seed load; gen_seed_i/gen_seed_q valid with it
//   gen_en            : advance generator one chip (one cycle after chip_en)
//   chip_cnt/slot_cnt : index of the chip flagged by gen_en
//   slot_start/frame_start : boundary flags accompanying gen_en
//   busy              : FSM in LOAD or RUN
//   err               : sticky, chip_en arrived while a seed load was pending
//   frame_cnt         : frame counter, only when SCRAMB_FRAME_CNT_EN is defined
// Build option: define SCRAMB_FRAME_CNT_EN to include the frame counter.
// -----------------------------------------------------------------------------
module scramb_code_ctrl
    import scramb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [SEED_W-1:0]  code_num,
    input  logic               cfg_wr,
    input  logic               chip_en,
    output logic               gen_load,
    output logic [SEED_W-1:0]  gen_seed_i,
    output logic [SEED_W-1:0]  gen_seed_q,
    output logic               gen_en,
    output logic [CHIP_W-1:0]  chip_cnt,
    output logic [SLOT_W-1:0]  slot_cnt,
    output logic               frame_start,
    output logic               slot_start,
    output logic               busy,
    output logic               err,
    output logic [FRAME_W-1:0] frame_cnt
);

    state_e state_q, state_d;

    logic [SEED_W-1:0] active_q, pend_q;
    logic              pend_vld_q;
    logic              wrap_q;          // last chip of frame issued; reload next
    logic              gen_en_q, slot_start_q, frame_start_q, err_q;
    logic [CHIP_W-1:0] chip_cnt_q;
    logic [SLOT_W-1:0] slot_cnt_q;

    logic              start_ok, stop_busy, accept, overrun, reload;
    logic [CHIP_W-1:0] cnt_chip;
    logic [SLOT_W-1:0] cnt_slot;
    logic              cnt_last;
    logic              first_chip_of_frame;

    assign busy      = (state_q != IDLE);
    assign start_ok  = (state_q == IDLE) && start && !stop;
    assign stop_busy = busy && stop;
    // While a reload is committed (wrap cycle or LOAD) there is no seed in the
    // generator to advance, so a chip strobe then is an overrun.
    assign accept    = (state_q == RUN) && !wrap_q && chip_en && !stop;
    assign overrun   = chip_en && ((state_q == LOAD) || ((state_q == RUN) && wrap_q));
    assign first_chip_of_frame = (cnt_chip == '0) && (cnt_slot == '0);

    scramb_chip_slot_cnt u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (accept),
        .clr       (stop_busy),
        .chip_cnt  (cnt_chip),
        .slot_cnt  (cnt_slot),
        .last_chip (cnt_last)
    );

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        reload  = 1'b0;
        case (state_q)
            IDLE: if (start_ok) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (wrap_q) begin
                    state_d = LOAD;
                    reload  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop_busy) begin
            state_d = IDLE;
            reload  = 1'b0;
        end

        // stop suppresses generator strobes in the very cycle it is seen.
        gen_load    = (state_q == LOAD) && !stop;
        gen_seed_i  = gen_load ? safe_seed(active_q) : '0;
        gen_seed_q  = gen_load ? Q_SEED : '0;
        gen_en      = gen_en_q && !stop;
        slot_start  = slot_start_q && !stop;
        frame_start = frame_start_q && !stop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            active_q      <= '0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            wrap_q        <= 1'b0;
            gen_en_q      <= 1'b0;
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            chip_cnt_q    <= '0;
            slot_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (overrun) err_q <= 1'b1;

            if (stop_busy) begin
                pend_vld_q    <= 1'b0;
                wrap_q        <= 1'b0;
                gen_en_q      <= 1'b0;
                slot_start_q  <= 1'b0;
                frame_start_q <= 1'b0;
                chip_cnt_q    <= '0;
                slot_cnt_q    <= '0;
            end else begin
                gen_en_q      <= accept;
                slot_start_q  <= accept && (cnt_chip == '0);
                frame_start_q <= accept && first_chip_of_frame;
                wrap_q        <= accept && cnt_last;
                if (accept) begin
                    chip_cnt_q <= cnt_chip;
                    slot_cnt_q <= cnt_slot;
                end

                // A cfg_wr coinciding with the reload decision is the most
                // recent write and goes straight into the active seed.
                if (start_ok) begin
                    active_q <= code_num;
                end else if (reload) begin
                    if (cfg_wr)          active_q <= code_num;
                    else if (pend_vld_q) active_q <= pend_q;
                end

                if (reload) begin
                    pend_vld_q <= 1'b0;
                end else if (busy && cfg_wr) begin
                    pend_q     <= code_num;
                    pend_vld_q <= 1'b1;
                end
            end
        end
    end

    assign chip_cnt = chip_cnt_q;
    assign slot_cnt = slot_cnt_q;
    assign err      = err_q;

`ifdef SCRAMB_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               first_frame_q;  // next frame_start is the first since start

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_q   <= '0;
            first_frame_q <= 1'b0;
        end else if (start_ok) begin
            frame_cnt_q   <= '0;
            first_frame_q <= 1'b1;
        end else if (accept && first_chip_of_frame) begin
            if (first_frame_q) first_frame_q <= 1'b0;
            else               frame_cnt_q   <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_scramb_code_ctrl.sv
module tb_scramb_code_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stop, cfg_wr, chip_en;
    logic [17:0] code_num;
    logic        gen_load, gen_en, frame_start, slot_start, busy, err;
    logic [17:0] gen_seed_i, gen_seed_q;
    logic [11:0] chip_cnt, frame_cnt;
    logic [3:0]  slot_cnt;

    always #5 clk = ~clk;

    scramb_code_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .code_num    (code_num),
        .cfg_wr      (cfg_wr),
        .chip_en     (chip_en),
        .gen_load    (gen_load),
        .gen_seed_i  (gen_seed_i),
        .gen_seed_q  (gen_seed_q),
        .gen_en      (gen_en),
        .chip_cnt    (chip_cnt),
        .slot_cnt    (slot_cnt),
        .frame_start (frame_start),
        .slot_start  (slot_start),
        .busy        (busy),
        .err         (err),
        .frame_cnt   (frame_cnt)
    );

`ifdef SCRAMB_FRAME_CNT_EN
    localparam logic [11:0] FC_SECOND = 12'd1;
`else
    localparam logic [11:0] FC_SECOND = 12'd0;
`endif

    typedef struct packed {
        logic [11:0] chip;
        logic [3:0]  slot;
        logic        ss;
        logic        fs;
        logic [11:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_chip, m_slot, m_fcnt;
    bit   m_first;
    int   n_gen_en, n_slot_start, n_frame_start, n_gen_load;

    // Reference model of the chip position; one entry per accepted chip_en.
    function automatic void push_chip();
        exp_t e;
        e.chip = 12'(m_chip);
        e.slot = 4'(m_slot);
        e.ss   = (m_chip == 0);
        e.fs   = (m_chip == 0) && (m_slot == 0);
`ifdef SCRAMB_FRAME_CNT_EN
        if (e.fs) begin
            if (m_first) m_first = 1'b0;
            else         m_fcnt  = (m_fcnt + 1) % 4096;
        end
        e.fcnt = 12'(m_fcnt);
`else
        e.fcnt = 12'd0;
`endif
        sb.push_back(e);
        m_chip++;
        if (m_chip == 2560) begin
            m_chip = 0;
            m_slot = (m_slot == 14) ? 0 : m_slot + 1;
        end
    endfunction

    // Output monitor: every gen_en must match the oldest expected chip.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (reset === 1'b1) begin
            if (gen_load === 1'b1) n_gen_load++;
            if (gen_en === 1'b1) begin
                n_gen_en++;
                if (slot_start === 1'b1)  n_slot_start++;
                if (frame_start === 1'b1) n_frame_start++;
                got = {chip_cnt, slot_cnt, slot_start, frame_start, frame_cnt};
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_gen_en got=%h required=none", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL chip_stream chip/slot/ss/fs/fcnt got=%0d/%0d/%b/%b/%0d required=%0d/%0d/%b/%b/%0d",
                                 chip_cnt, slot_cnt, slot_start, frame_start, frame_cnt,
                                 e.chip, e.slot, e.ss, e.fs, e.fcnt);
                    end
                end
            end else if (slot_start === 1'b1 || frame_start === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL stray_boundary_pulse got ss=%b fs=%b required=0/0", slot_start, frame_start);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_wr = 1'b0; chip_en = 1'b0;
        code_num = 18'h0;
        tick();
        tick();
        reset = 1'b1;
        sb.delete();
        n_gen_en = 0; n_slot_start = 0; n_frame_start = 0; n_gen_load = 0;
    endtask

    task automatic do_start(input logic [17:0] cn);
        code_num = cn;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        m_chip = 0; m_slot = 0; m_fcnt = 0; m_first = 1'b1;
    endtask

    task automatic run_chips(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            chip_en = 1'b1;
            push_chip();
            tick();
            chip_en = 1'b0;
            for (int g = 1; g < gap; g++) tick();
        end
        chip_en = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1; chip_en = 1'b1;
        do_reset();
        checks++;
        if ({busy, gen_load, gen_en, slot_start, frame_start, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=000000",
                     {busy, gen_load, gen_en, slot_start, frame_start, err});
        end
        checks++;
        if ({gen_seed_i, gen_seed_q, chip_cnt, slot_cnt, frame_cnt} !== 64'h0) begin
            failures++;
            $display("FAIL reset_values got=%h/%h/%0d/%0d/%0d required=0",
                     gen_seed_i, gen_seed_q, chip_cnt, slot_cnt, frame_cnt);
        end
    endtask

    // First load, a full frame with mid-frame cfg_wr, then the reload.
    task automatic test_frame();
        int base_load;
        do_reset();
        do_start(18'h00001);
        checks++;
        if ({gen_load, busy, gen_seed_i, gen_seed_q} !== {2'b11, 18'h00001, 18'h3FFFF}) begin
            failures++;
            $display("FAIL first_load got load=%b busy=%b si=%h sq=%h required 1/1/00001/3ffff",
                     gen_load, busy, gen_seed_i, gen_seed_q);
        end
        tick();
        checks++;
        if (gen_load !== 1'b0) begin
            failures++;
            $display("FAIL load_one_cycle got=%b required=0", gen_load);
        end
        run_chips(16, 4);
        base_load = n_gen_load;
        for (int k = 16; k < 38400; k++) begin
            cfg_wr   = (k == 1000) || (k == 2000);
            code_num = (k == 1000) ? 18'h00ABC : (k == 2000) ? 18'h00123 : 18'h3AAAA;
            chip_en  = 1'b1;
            push_chip();
            tick();
        end
        chip_en = 1'b0; cfg_wr = 1'b0; code_num = 18'h2F0F0;
        checks++;
        if (n_gen_load !== base_load) begin
            failures++;
            $display("FAIL no_midframe_load got=%0d required=%0d", n_gen_load, base_load);
        end
        for (int i = 0; i < 8 && gen_load !== 1'b1; i++) tick();
        checks++;
        if ({gen_load, gen_seed_i, gen_seed_q} !== {1'b1, 18'h00123, 18'h3FFFF}) begin
            failures++;
            $display("FAIL frame_reload got load=%b si=%h sq=%h required 1/00123/3ffff",
                     gen_load, gen_seed_i, gen_seed_q);
        end
        checks++;
        if (n_slot_start !== 15 || n_frame_start !== 1) begin
            failures++;
            $display("FAIL boundary_counts got slots=%0d frames=%0d required 15/1", n_slot_start, n_frame_start);
        end
        tick();
        checks++;
        if (gen_load !== 1'b0) begin
            failures++;
            $display("FAIL reload_one_cycle got=%b required=0", gen_load);
        end
        chip_en = 1'b1;
        push_chip();
        tick();
        chip_en = 1'b0;
        checks++;
        if ({gen_en, frame_start, frame_cnt} !== {2'b11, FC_SECOND}) begin
            failures++;
            $display("FAIL second_frame_start got en=%b fs=%b fcnt=%0d required 1/1/%0d",
                     gen_en, frame_start, frame_cnt, FC_SECOND);
        end
        tick();
        checks++;
        if (sb.size() != 0 || n_gen_load !== 2) begin
            failures++;
            $display("FAIL frame_drain got pending=%0d loads=%0d required 0/2", sb.size(), n_gen_load);
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        do_start(18'h00000);
        checks++;
        if ({gen_load, gen_seed_i} !== {1'b1, 18'h00001}) begin
            failures++;
            $display("FAIL zero_seed got load=%b si=%h required 1/00001", gen_load, gen_seed_i);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        chip_en = 1'b1;
        tick();
        chip_en = 1'b0;
        checks++;
        if ({err, gen_en, busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_chip_en got err/en/busy=%b required 000", {err, gen_en, busy});
        end
        do_start(18'h00005);
        chip_en = 1'b1;          // coincides with LOAD
        tick();
        chip_en = 1'b0;
        checks++;
        if ({err, gen_en, chip_cnt} !== {2'b10, 12'd0}) begin
            failures++;
            $display("FAIL overrun got err=%b en=%b chip=%0d required 1/0/0", err, gen_en, chip_cnt);
        end
        run_chips(3, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++;
        if ({err, busy, sb.size() == 0} !== 3'b101) begin
            failures++;
            $display("FAIL err_sticky got err=%b busy=%b drained=%b required 1/0/1", err, busy, sb.size() == 0);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_reset got=%b required=0", err);
        end
    endtask

    task automatic test_stop();
        int base_en;
        do_reset();
        do_start(18'h00007);
        tick();
        start = 1'b1; code_num = 18'h01111;   // ignored while busy
        tick();
        start = 1'b0;
        checks++;
        if ({gen_load, busy} !== 2'b01) begin
            failures++;
            $display("FAIL start_while_busy got load=%b busy=%b required 0/1", gen_load, busy);
        end
        run_chips(5000, 1);
        tick();
        checks++;
        if ({chip_cnt, slot_cnt} !== {12'd2439, 4'd1}) begin
            failures++;
            $display("FAIL pre_stop_pos got %0d/%0d required 2439/1", chip_cnt, slot_cnt);
        end
        stop = 1'b1; chip_en = 1'b1; cfg_wr = 1'b1;
        tick();
        stop = 1'b0; cfg_wr = 1'b0;
        base_en = n_gen_en;
        checks++;
        if ({busy, gen_en, chip_cnt, slot_cnt} !== 18'h0) begin
            failures++;
            $display("FAIL stop_idle got busy=%b en=%b chip=%0d slot=%0d required 0/0/0/0",
                     busy, gen_en, chip_cnt, slot_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        chip_en = 1'b0;
        checks++;
        if (n_gen_en !== base_en) begin
            failures++;
            $display("FAIL gen_en_after_stop got=%0d required=%0d", n_gen_en, base_en);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({busy, gen_load} !== 2'b00) begin
            failures++;
            $display("FAIL start_with_stop got busy=%b load=%b required 0/0", busy, gen_load);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        do_start(18'h00ABC);
        tick();
        run_chips(50, 1);
        cfg_wr = 1'b1; code_num = 18'h00555;
        tick();
        cfg_wr = 1'b0;
        run_chips(50, 1);
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, chip_cnt, slot_cnt, gen_en} !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_frame got busy=%b chip=%0d slot=%0d en=%b required 0/0/0/0",
                     busy, chip_cnt, slot_cnt, gen_en);
        end
        reset = 1'b1;
        sb.delete();
        do_start(18'h00777);
        checks++;
        if ({gen_load, gen_seed_i} !== {1'b1, 18'h00777}) begin
            failures++;
            $display("FAIL restart_seed got load=%b si=%h required 1/00777", gen_load, gen_seed_i);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_zero_seed();
        test_overrun();
        test_stop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog_timeout got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
